// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples rx on clk_16x ticks, validates the start bit at
// mid-bit, shifts data LSB-first and reports each frame as a one-cycle pulse.
module uart_rx #(
    parameter int BAUD_TICK_COUNT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_16x,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       rx_busy,
    output logic [2:0] dbg_state
);

    localparam int HALF = BAUD_TICK_COUNT / 2;
    localparam int CW   = $clog2(BAUD_TICK_COUNT);

    // Counter compares use the pre-increment value, so the start sample lands
    // HALF-1 ticks after the detect tick and each later sample one bit period on.
    localparam logic [CW-1:0] START_LAST = CW'(HALF - 2);
    localparam logic [CW-1:0] BIT_LAST   = CW'(BAUD_TICK_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_d;
    logic          valid_d, err_d;
    logic          rx_s1, rx_s2;
    logic          clk16_d;
    logic          tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            clk16_d <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            clk16_d <= clk_16x;
        end
    end

    assign tick = clk_16x & ~clk16_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rx_data    <= data_d;
            rx_valid   <= valid_d;
            rx_err     <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = rx_data;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s2) begin
                        state_d    = S_START;
                        tick_cnt_d = '0;
                    end
                end
                S_START: begin
                    if (tick_cnt_q == START_LAST) begin
                        if (rx_s2) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d    = S_DATA;
                            tick_cnt_d = '0;
                            bit_idx_d  = '0;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_cnt_q == BIT_LAST) begin
                        shift_d    = {rx_s2, shift_q[7:1]};
                        tick_cnt_d = '0;
                        if (bit_idx_q == 3'd7) begin
                            state_d = S_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        if (rx_s2) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    // A held-low line must return high before a new start is armed.
                    if (rx_s2) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign rx_busy   = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames, checked against a
// byte-level expectation queue filled as frames are put on the line.
module tb_uart_rx;

    localparam int CPT      = 4;          // clk cycles per clk_16x tick
    localparam int TPB      = 16;         // ticks per bit
    localparam int BIT_CLKS = CPT * TPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_16x;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       rx_busy;
    logic [2:0] dbg_state;
    logic [1:0] div = 2'd0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int err_pending = 0;
    int busy_run = 0;
    int busy_max = 0;
    logic prev_busy = 1'b0;
    logic [7:0] exp_q[$];
    int valid_cyc[$];

    uart_rx #(.BAUD_TICK_COUNT(TPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_16x   (clk_16x),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err),
        .rx_busy   (rx_busy),
        .dbg_state (dbg_state)
    );

    // Clock and oversampling strobe: one tick every CPT clk cycles.
    always #5 clk = ~clk;
    always @(posedge clk) begin
        div <= div + 2'd1;
        cyc <= cyc + 1;
    end
    assign clk_16x = div[1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT_CLKS) @(posedge clk);
    endtask

    task automatic idle_ticks(input int n);
        rx = 1'b1;
        repeat (n * CPT) @(posedge clk);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge clk_16x);
    endtask

    // Expectations are queued before the frame, since the pulse lands inside the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) exp_q.push_back(b);
        else err_pending++;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
    endtask

    // Transmitter stand-in sharing clk_16x: bit edges aligned to ticks.
    task automatic tx_model(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        exp_q.push_back(b);
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            wait_ticks(TPB);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rx_valid) begin
            valid_cnt++;
            valid_cyc.push_back(cyc);
            check("valid_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rx_data_on_valid", 32'(rx_data), 32'(e));
            end
            check("busy_low_with_valid", 32'(rx_busy), 0);
            check("busy_high_before_valid", 32'(prev_busy), 1);
            check("valid_err_exclusive", 32'(rx_err), 0);
        end
        if (rx_err) begin
            err_cnt++;
            check("err_expected", 32'(err_pending > 0), 1);
            if (err_pending > 0) err_pending--;
            check("busy_high_with_err", 32'(rx_busy), 1);
        end
        if (rx_busy) begin
            busy_run++;
        end else begin
            if (busy_run > busy_max) busy_max = busy_run;
            busy_run = 0;
        end
        prev_busy = rx_busy;
    end

    initial begin
        int v0, e0, n0;
        logic [7:0] b;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 0);
        check("reset_rx_valid", 32'(rx_valid), 0);
        check("reset_rx_err", 32'(rx_err), 0);
        check("reset_rx_busy", 32'(rx_busy), 0);
        rst = 1'b0;
        idle_ticks(20);

        // Single frame 0xA5
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'hA5, 1'b1);
        idle_ticks(8);
        @(negedge clk);
        check("a5_valid_count", 32'(valid_cnt - v0), 1);
        check("a5_err_count", 32'(err_cnt - e0), 0);
        check("a5_rx_data", 32'(rx_data), 32'h A5);
        check("a5_busy_idle", 32'(rx_busy), 0);

        // Back-to-back 0x00, 0xFF: pulses one frame (160 ticks) apart
        v0 = valid_cnt; n0 = valid_cyc.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_ticks(8);
        @(negedge clk);
        check("b2b_valid_count", 32'(valid_cnt - v0), 2);
        check("b2b_rx_data", 32'(rx_data), 32'h FF);
        if (valid_cyc.size() >= n0 + 2)
            check("b2b_spacing", 32'(valid_cyc[n0+1] - valid_cyc[n0]), 32'(10 * BIT_CLKS));
        else
            check("b2b_pulses_seen", 32'(valid_cyc.size() - n0), 2);

        // False start: 4 ticks low
        v0 = valid_cnt; e0 = err_cnt; busy_max = 0;
        rx = 1'b0;
        repeat (4 * CPT) @(posedge clk);
        idle_ticks(24);
        @(negedge clk);
        check("fs_valid_count", 32'(valid_cnt - v0), 0);
        check("fs_err_count", 32'(err_cnt - e0), 0);
        check("fs_rx_data", 32'(rx_data), 32'h FF);
        check("fs_busy_len", 32'(busy_max > 0 && busy_max <= 8 * CPT), 1);
        check("fs_busy_idle", 32'(rx_busy), 0);

        // Framing error on 0x3C, line held low, then 0x55
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (20 * CPT) @(posedge clk);
        @(negedge clk);
        check("brk_err_count", 32'(err_cnt - e0), 1);
        check("brk_busy_held", 32'(rx_busy), 1);
        repeat (20 * CPT) @(posedge clk);
        @(negedge clk);
        check("brk_no_valid", 32'(valid_cnt - v0), 0);
        check("brk_no_extra_err", 32'(err_cnt - e0), 1);
        check("brk_rx_data_kept", 32'(rx_data), 32'h FF);
        idle_ticks(16);
        send_frame(8'h55, 1'b1);
        idle_ticks(8);
        @(negedge clk);
        check("brk_55_valid", 32'(valid_cnt - v0), 1);
        check("brk_55_rx_data", 32'(rx_data), 32'h 55);

        // Reset during data bit 4 of 0xC3
        v0 = valid_cnt; e0 = err_cnt;
        b = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        repeat (BIT_CLKS / 2) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_rx_data", 32'(rx_data), 0);
        check("rst_mid_rx_busy", 32'(rx_busy), 0);
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_rx_valid", 32'(rx_valid), 0);
        check("rst_mid_rx_err", 32'(rx_err), 0);
        rst = 1'b0;
        idle_ticks(TPB * 12);
        @(negedge clk);
        check("rst_no_pulse", 32'(valid_cnt - v0 + err_cnt - e0), 0);
        send_frame(8'h81, 1'b1);
        idle_ticks(8);
        @(negedge clk);
        check("rst_81_rx_data", 32'(rx_data), 32'h 81);
        check("rst_81_valid", 32'(valid_cnt - v0), 1);

        // Tick-aligned loopback stream
        v0 = valid_cnt; e0 = err_cnt;
        tx_model(8'h5A);
        tx_model(8'h81);
        tx_model(8'hFF);
        idle_ticks(8);
        @(negedge clk);
        check("loop_valid_count", 32'(valid_cnt - v0), 3);
        check("loop_err_count", 32'(err_cnt - e0), 0);
        check("loop_rx_data", 32'(rx_data), 32'h FF);

        // Random bytes with random idle gaps
        for (int k = 0; k < 20; k++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            @(negedge clk);
            check("rand_rx_data", 32'(rx_data), 32'(b));
            idle_ticks($urandom_range(0, 20));
        end

        idle_ticks(40);
        @(negedge clk);
        check("end_exp_q_empty", 32'(exp_q.size()), 0);
        check("end_err_pending", 32'(err_pending), 0);
        check("end_busy_idle", 32'(rx_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
